pb_key_fifo: RTL and testbench

- Input-conditioning stage directly upstream of the calculator/CPU core (top1) on the FPGA board.
- Synchronises and debounces the 21 raw pushbuttons, then encodes each accepted press as one 5-bit key code.
- Buffers key codes in a small first-word-fall-through FIFO with a valid/ready handshake, so the consumer never misses or double-counts a key.

---
 rtl/pb_key_pkg.sv | 45 ++++
 rtl/key_fifo.sv | 76 +++++++
 rtl/pb_key_fifo.sv | 159 +++++++++++++++
 tb/tb_pb_key_fifo.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pb_key_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pb_key_pkg
//  Description : Shared types and constants for the pushbutton key FIFO:
//                key code type, debouncer state encoding and the symbolic
//                key codes (hex digits 0..F and five command keys).
//  Revision    : 1.0 - initial release
// ============================================================================
package pb_key_pkg;

    localparam int KEY_W = 5;

    typedef logic [KEY_W-1:0] key_code_t;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } db_state_t;

    localparam key_code_t KEY_0    = 5'd0;
    localparam key_code_t KEY_1    = 5'd1;
    localparam key_code_t KEY_2    = 5'd2;
    localparam key_code_t KEY_3    = 5'd3;
    localparam key_code_t KEY_4    = 5'd4;
    localparam key_code_t KEY_5    = 5'd5;
    localparam key_code_t KEY_6    = 5'd6;
    localparam key_code_t KEY_7    = 5'd7;
    localparam key_code_t KEY_8    = 5'd8;
    localparam key_code_t KEY_9    = 5'd9;
    localparam key_code_t KEY_A    = 5'd10;
    localparam key_code_t KEY_B    = 5'd11;
    localparam key_code_t KEY_C    = 5'd12;
    localparam key_code_t KEY_D    = 5'd13;
    localparam key_code_t KEY_E    = 5'd14;
    localparam key_code_t KEY_F    = 5'd15;
    localparam key_code_t KEY_CMD0 = 5'd16;
    localparam key_code_t KEY_CMD1 = 5'd17;
    localparam key_code_t KEY_CMD2 = 5'd18;
    localparam key_code_t KEY_CMD3 = 5'd19;
    localparam key_code_t KEY_CMD4 = 5'd20;

endpackage : pb_key_pkg
`default_nettype wire

// File: rtl/key_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : key_fifo
//  Description : Small first-word-fall-through FIFO for key codes.
//                The head entry is presented combinationally on pop_data
//                (zero when empty). A push while full is accepted only if a
//                pop happens in the same cycle; a pop while empty is ignored.
//  Ports       : clk, nrst (sync, active-low)
//                push, push_data   - write request and data
//                pop               - consume head (ignored when empty)
//                pop_data          - head entry
//                full, empty       - occupancy flags
//  Revision    : 1.0 - initial release
// ============================================================================
module key_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 5
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             push_ok;
    logic             pop_ok;

    assign full  = (count == CNT_W'(FIFO_DEPTH));
    assign empty = (count == '0);

    // A full FIFO still accepts a push when the head is leaving this cycle.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are exactly PTR_W bits wide, so increment wraps modulo depth.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule : key_fifo
`default_nettype wire

// File: rtl/pb_key_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : pb_key_fifo
//  Description : Pushbutton conditioning: two-flop synchroniser, debounce
//                FSM with lowest-index priority encoding, and a key-code
//                FIFO with valid/ready handshake and sticky overflow flag.
//  Ports       : clk, nrst (sync, active-low)
//                pb[NUM_PB]   - raw pushbutton levels, 1 = pressed
//                key_code[5]  - FIFO head code (0 when empty)
//                key_valid    - FIFO non-empty
//                key_ready    - consumer accepts head
//                overflow     - sticky, a key was dropped on a full FIFO
//                ovf_clr      - clears overflow (set wins)
//                busy         - debouncer not idle
//  Revision    : 1.0 - initial release
// ============================================================================
module pb_key_fifo
    import pb_key_pkg::*;
#(
    parameter int NUM_PB          = 21,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [NUM_PB-1:0] pb,
    output logic [4:0]        key_code,
    output logic              key_valid,
    input  logic              key_ready,
    output logic              overflow,
    input  logic              ovf_clr,
    output logic              busy
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_PB-1:0] s1;
    logic [NUM_PB-1:0] s2;
    db_state_t         state;
    db_state_t         state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    key_code_t         code;
    key_code_t         code_nxt;
    key_code_t         enc;
    logic              push;
    logic              fifo_full;
    logic              fifo_empty;

    // Two-flop synchroniser; only s2 is seen by the debouncer.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= pb;
            s2 <= s1;
        end
    end

    // Lowest set index wins: scan from the top so the last hit is the lowest.
    always_comb begin
        enc = '0;
        for (int i = NUM_PB - 1; i >= 0; i--) begin
            if (s2[i]) begin
                enc = key_code_t'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            code  <= code_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        code_nxt  = code;
        push      = 1'b0;
        case (state)
            IDLE: begin
                if (|s2) begin
                    code_nxt  = enc;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                // Only the captured button matters; others are ignored.
                if (!s2[code]) begin
                    state_nxt = IDLE;
                end else if (cnt == CNT_LAST) begin
                    push      = 1'b1;
                    state_nxt = HELD;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            HELD: begin
                if (s2 == '0) begin
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (|s2) begin
                    state_nxt = HELD;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state != IDLE);

    key_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (KEY_W)
    ) u_key_fifo (
        .clk       (clk),
        .nrst      (nrst),
        .push      (push),
        .push_data (code),
        .pop       (key_ready),
        .pop_data  (key_code),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign key_valid = !fifo_empty;

    // A push is dropped only when full and the head is not leaving.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !key_ready) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule : pb_key_fifo
`default_nettype wire

// File: tb/tb_pb_key_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pb_key_fifo
//  Description : Directed self-checking bench for pb_key_fifo with the
//                default parameters (21 buttons, 3-cycle debounce, depth 4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pb_key_fifo;

    logic        clk;
    logic        nrst;
    logic [20:0] pb;
    logic [4:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        overflow;
    logic        ovf_clr;
    logic        busy;

    int errors = 0;
    int checks = 0;

    pb_key_fifo #(
        .NUM_PB          (21),
        .DEBOUNCE_CYCLES (3),
        .FIFO_DEPTH      (4)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pb        (pb),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges and settle 1 time unit past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clean debounced press and full release of a single button.
    task automatic press(input int idx);
        pb = 21'd1 << idx;
        tick(5);
        pb = '0;
        tick(6);
    endtask

    task automatic pop_one;
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
    endtask

    initial begin
        nrst      = 1'b0;
        pb        = '0;
        key_ready = 1'b0;
        ovf_clr   = 1'b0;
        tick(2);
        check("rst_valid", 32'(key_valid), 0);
        check("rst_code", 32'(key_code), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_ovf", 32'(overflow), 0);
        nrst = 1'b1;
        tick(1);

        // Clean press of pb[7]: push on edge 5.
        pb = 21'd1 << 7;
        tick(4);
        check("clean_before_lat", 32'(key_valid), 0);
        check("clean_busy", 32'(busy), 1);
        tick(1);
        check("clean_valid", 32'(key_valid), 1);
        check("clean_code", 32'(key_code), 7);
        tick(5);
        check("clean_hold_valid", 32'(key_valid), 1);
        check("clean_hold_code", 32'(key_code), 7);
        pb = '0;
        tick(6);
        check("clean_idle", 32'(busy), 0);
        check("clean_no_repeat", 32'(key_valid), 1);
        pop_one();
        check("clean_popped", 32'(key_valid), 0);
        check("clean_empty_code", 32'(key_code), 0);

        // Bounce: high 2, low 1, high 1, low.
        pb = 21'd1 << 3;
        tick(2);
        pb = '0;
        tick(1);
        pb = 21'd1 << 3;
        tick(1);
        pb = '0;
        tick(6);
        check("bounce_valid", 32'(key_valid), 0);
        check("bounce_busy", 32'(busy), 0);

        // Simultaneous pb[12]+pb[4] -> key 4; pb[9] added while held.
        pb = (21'd1 << 12) | (21'd1 << 4);
        tick(5);
        check("simul_valid", 32'(key_valid), 1);
        check("simul_code", 32'(key_code), 4);
        pb = pb | (21'd1 << 9);
        tick(8);
        pb = '0;
        tick(6);
        pop_one();
        check("extra_ignored", 32'(key_valid), 0);
        pb = 21'd1 << 9;
        tick(5);
        check("repress_code", 32'(key_code), 9);
        pb = '0;
        tick(6);
        pop_one();
        check("repress_popped", 32'(key_valid), 0);

        // Overflow: five presses into a depth-4 FIFO.
        for (int k = 1; k <= 5; k++) press(k);
        check("ovf_set", 32'(overflow), 1);
        for (int k = 1; k <= 4; k++) begin
            check("ovf_order", 32'(key_code), 32'(k));
            pop_one();
        end
        check("ovf_drained", 32'(key_valid), 0);
        check("ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("ovf_cleared", 32'(overflow), 0);

        // Full FIFO with a pop on the push cycle of code 16.
        for (int k = 10; k <= 13; k++) press(k);
        pb = 21'd1 << 16;
        tick(4);
        key_ready = 1'b1;
        tick(1);
        key_ready = 1'b0;
        check("fullpop_ovf", 32'(overflow), 0);
        check("fullpop_head", 32'(key_code), 11);
        pb = '0;
        tick(6);
        check("fullpop_q1", 32'(key_code), 11);
        pop_one();
        check("fullpop_q2", 32'(key_code), 12);
        pop_one();
        check("fullpop_q3", 32'(key_code), 13);
        pop_one();
        check("fullpop_q4", 32'(key_code), 16);
        pop_one();
        check("fullpop_empty", 32'(key_valid), 0);

        // Reset mid-operation with pb[6] held through it.
        press(2);
        press(3);
        pb = 21'd1 << 6;
        tick(3);
        check("midrst_busy_pre", 32'(busy), 1);
        check("midrst_valid_pre", 32'(key_valid), 1);
        nrst = 1'b0;
        tick(1);
        nrst = 1'b1;
        check("midrst_valid", 32'(key_valid), 0);
        check("midrst_ovf", 32'(overflow), 0);
        check("midrst_busy", 32'(busy), 0);
        tick(4);
        check("midrst_before_lat", 32'(key_valid), 0);
        tick(1);
        check("midrst_new_valid", 32'(key_valid), 1);
        check("midrst_new_code", 32'(key_code), 6);
        pb = '0;
        tick(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Hard time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_pb_key_fifo
`default_nettype wire
